// File: rtl/idu_ctrl.sv
// idu_ctrl: decode-stage controller for the single-issue RV64 core.
// Holds one instruction between IFU and EXU, classifies it, halts on ebreak.
module idu_ctrl #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [2:0]       imm_sel,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             illegal,
  output logic             is_ebreak,
  output logic             halted,
  output logic [CNT_W-1:0] dec_count
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FULL,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;

  // r_live keeps in_ready low until the first edge after reset release.
  logic r_live;

  logic w_in_ready;
  logic w_out_valid;
  logic w_accept;
  logic w_consume;
  logic w_take;

  logic [6:0] w_op;
  logic       w_op_i;
  logic       w_op_u;
  logic       w_op_s;
  logic       w_op_j;
  logic       w_op_b;
  logic       w_op_r;
  logic [2:0] w_imm;
  logic       w_ill;
  logic       w_ebk;

  logic [31:0]      r_instr;
  logic [PC_W-1:0]  r_pc;
  logic [2:0]       r_imm;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic             r_ill;
  logic             r_ebk;
  logic [CNT_W-1:0] r_cnt;

  assign w_op   = in_instr[6:0];
  assign w_op_i = (w_op == 7'b0000011) |
                  (w_op == 7'b0010011) |
                  (w_op == 7'b0011011) |
                  (w_op == 7'b1100111) |
                  (w_op == 7'b1110011);
  assign w_op_u = (w_op == 7'b0110111) |
                  (w_op == 7'b0010111);
  assign w_op_s = (w_op == 7'b0100011);
  assign w_op_j = (w_op == 7'b1101111);
  assign w_op_b = (w_op == 7'b1100011);
  assign w_op_r = (w_op == 7'b0110011) |
                  (w_op == 7'b0111011);
  assign w_ebk  = (in_instr == EBREAK);

  // Opcode classification into immediate type; unknown opcodes are illegal.
  always_comb begin
    w_imm = 3'd0;
    w_ill = 1'b0;
    unique case (1'b1)
      w_op_i:  w_imm = 3'd1;
      w_op_u:  w_imm = 3'd2;
      w_op_s:  w_imm = 3'd3;
      w_op_j:  w_imm = 3'd4;
      w_op_b:  w_imm = 3'd5;
      w_op_r:  w_imm = 3'd0;
      default: w_ill = 1'b1;
    endcase
  end

  // Handshake outputs and next state; flush wins except in HALT.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_next      = r_state;
    unique case (r_state)
      S_EMPTY: w_in_ready = r_live & ~flush;
      S_FULL: begin
        w_out_valid = 1'b1;
        w_in_ready  = out_ready & ~flush;
      end
      S_DRAIN: w_out_valid = 1'b1;
      S_HALT:  w_in_ready  = 1'b0;
    endcase
    if (flush && (r_state != S_HALT)) begin
      w_next = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (in_valid & w_in_ready)
            w_next = w_ebk ? S_DRAIN : S_FULL;
        end
        S_FULL: begin
          if (in_valid & w_in_ready)
            w_next = w_ebk ? S_DRAIN : S_FULL;
          else if (out_ready)
            w_next = S_EMPTY;
        end
        S_DRAIN: begin
          if (out_ready)
            w_next = S_HALT;
        end
        S_HALT: w_next = S_HALT;
      endcase
    end
  end

  assign w_accept  = in_valid & w_in_ready;
  assign w_consume = w_out_valid & out_ready;
  assign w_take    = w_consume & ~flush;

  // State register plus post-reset enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  // Decode register: loaded only on accept, otherwise held stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_ill   <= 1'b0;
      r_ebk   <= 1'b0;
    end else if (w_accept) begin
      r_instr <= in_instr;
      r_pc    <= in_pc;
      r_imm   <= w_imm;
      r_rs1   <= in_instr[19:15];
      r_rs2   <= in_instr[24:20];
      r_rd    <= in_instr[11:7];
      r_ill   <= w_ill;
      r_ebk   <= w_ebk;
    end
  end

  // Count instructions handed to the EXU; flushed consumes do not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_take)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_instr = r_instr;
  assign out_pc    = r_pc;
  assign imm_sel   = r_imm;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign rd        = r_rd;
  assign illegal   = r_ill;
  assign is_ebreak = r_ebk;
  assign halted    = (r_state == S_HALT);
  assign dec_count = r_cnt;

endmodule

// File: tb/tb_idu_ctrl.sv
// tb_idu_ctrl: vector table, directed sequences and random traffic
// checked against a transaction-level model of the decode slot.
module tb_idu_ctrl;

  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  imm_sel;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        illegal;
  logic        is_ebreak;
  logic        halted;
  logic [31:0] dec_count;

  idu_ctrl #(.PC_W(64), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .imm_sel(imm_sel), .rs1(rs1), .rs2(rs2), .rd(rd),
    .illegal(illegal), .is_ebreak(is_ebreak),
    .halted(halted), .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: one slot (valid, word, pc), halt flag, counter, live flag
  logic        m_v;
  logic [31:0] m_instr;
  logic [63:0] m_pc;
  logic        m_halt;
  logic [31:0] m_cnt;
  logic        m_live;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  imm;
    logic        ill;
  } vec_t;

  vec_t vt [0:11];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic logic [3:0] ref_dec(input logic [31:0] w);
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b0011011,
      7'b1100111, 7'b1110011: return {1'b0, 3'd1};
      7'b0110111, 7'b0010111: return {1'b0, 3'd2};
      7'b0100011:             return {1'b0, 3'd3};
      7'b1101111:             return {1'b0, 3'd4};
      7'b1100011:             return {1'b0, 3'd5};
      7'b0110011, 7'b0111011: return {1'b0, 3'd0};
      default:                return {1'b1, 3'd0};
    endcase
  endfunction

  task automatic chk_outs();
    logic [3:0] d;
    chk("out_valid", out_valid, m_v);
    chk("halted", halted, m_halt);
    chk("dec_count", dec_count, m_cnt);
    if (m_v) begin
      d = ref_dec(m_instr);
      chk("out_instr", out_instr, m_instr);
      chk("out_pc", out_pc, m_pc);
      chk("imm_sel", imm_sel, d[2:0]);
      chk("illegal", illegal, d[3]);
      chk("is_ebreak", is_ebreak, m_instr == EBRK);
      chk("rs1", rs1, m_instr[19:15]);
      chk("rs2", rs2, m_instr[24:20]);
      chk("rd", rd, m_instr[11:7]);
    end
  endtask

  // one clock: drive, check in_ready, clock, update model, check outputs
  task automatic cycle(input logic iv, input logic [31:0] ins,
                       input logic [63:0] pc, input logic ordy,
                       input logic fl);
    logic mr;
    logic acc;
    logic cons;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    mr = m_live && !m_halt && !fl &&
         (!m_v || (m_instr != EBRK && ordy));
    chk("in_ready", in_ready, mr);
    acc  = iv && mr;
    cons = m_v && ordy && !fl;
    @(posedge clk);
    #1;
    m_live = 1'b1;
    if (!m_halt) begin
      if (fl) begin
        m_v = 1'b0;
      end else begin
        if (cons) m_cnt = m_cnt + 1;
        if (cons && m_instr == EBRK) begin
          m_halt = 1'b1;
          m_v    = 1'b0;
        end else if (acc) begin
          m_v     = 1'b1;
          m_instr = ins;
          m_pc    = pc;
        end else if (cons) begin
          m_v = 1'b0;
        end
      end
    end
    chk_outs();
  endtask

  // reset asserted between edges; outputs must clear without a clock
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_dec_count", dec_count, 32'd0);
    chk("rst_imm_sel", imm_sel, 3'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    m_v = 1'b0; m_instr = '0; m_pc = '0;
    m_halt = 1'b0; m_cnt = '0; m_live = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] pool [0:7];

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    m_v = 1'b0; m_instr = '0; m_pc = '0;
    m_halt = 1'b0; m_cnt = '0; m_live = 1'b0;

    vt[0]  = '{32'h00500093, 3'd1, 1'b0};
    vt[1]  = '{32'h0000a103, 3'd1, 1'b0};
    vt[2]  = '{32'h000012b7, 3'd2, 1'b0};
    vt[3]  = '{32'h00000197, 3'd2, 1'b0};
    vt[4]  = '{32'h00112023, 3'd3, 1'b0};
    vt[5]  = '{32'h008000ef, 3'd4, 1'b0};
    vt[6]  = '{32'h00208463, 3'd5, 1'b0};
    vt[7]  = '{32'h002081b3, 3'd0, 1'b0};
    vt[8]  = '{32'h002081bb, 3'd0, 1'b0};
    vt[9]  = '{32'h0000007f, 3'd0, 1'b1};
    vt[10] = '{32'h00000000, 3'd0, 1'b1};
    vt[11] = '{32'h00000073, 3'd1, 1'b0};

    pool[0] = 32'h00500093; pool[1] = 32'h000012b7;
    pool[2] = 32'h00112023; pool[3] = 32'h008000ef;
    pool[4] = 32'h00208463; pool[5] = 32'h002081b3;
    pool[6] = 32'h0000007f; pool[7] = 32'h00000073;

    @(posedge clk);
    #1;
    do_reset();

    // first cycle after release: in_ready still low
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // stream of addi at 0x80000000, one per cycle
    cycle(1'b1, 32'h00500093, 64'h8000_0000, 1'b1, 1'b0);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_imm", imm_sel, 3'd1);
    chk("addi_rd", rd, 5'd1);
    chk("addi_rs1", rs1, 5'd0);
    chk("addi_pc", out_pc, 64'h8000_0000);
    for (int i = 1; i < 5; i++)
      cycle(1'b1, 32'h00500093, 64'h8000_0000 + 64'(4 * i), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    chk("stream_count", dec_count, 32'd5);

    // classification table, streamed back to back
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, vt[i].instr, 64'h1000 + 64'(4 * i), 1'b1, 1'b0);
      chk("tbl_imm", imm_sel, vt[i].imm);
      chk("tbl_ill", illegal, vt[i].ill);
      chk("tbl_instr", out_instr, vt[i].instr);
    end

    // backpressure: five stalled cycles, then release
    cycle(1'b1, 32'h000012b7, 64'h2000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h00112023, 64'h2004, 1'b0, 1'b0);
      chk("bp_hold_instr", out_instr, 32'h000012b7);
      chk("bp_hold_pc", out_pc, 64'h2000);
    end
    cycle(1'b1, 32'h00112023, 64'h2004, 1'b1, 1'b0);
    chk("bp_next_instr", out_instr, 32'h00112023);
    chk("bp_next_imm", imm_sel, 3'd3);

    // flush while FULL with a consume and an incoming beat
    cycle(1'b1, 32'h008000ef, 64'h3000, 1'b1, 1'b1);
    chk("flush_valid", out_valid, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    chk("flush_still_empty", out_valid, 1'b0);

    // async reset mid-transfer with a non-zero count
    cycle(1'b1, 32'h002081b3, 64'h4000, 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

    // ebreak: drain, halt, flush ignored, reset recovers
    cycle(1'b1, EBRK, 64'h5000, 1'b0, 1'b0);
    chk("ebk_flag", is_ebreak, 1'b1);
    cycle(1'b1, 32'h00500093, 64'h5004, 1'b1, 1'b0);
    chk("ebk_halted", halted, 1'b1);
    cycle(1'b1, 32'h00500093, 64'h5004, 1'b1, 1'b1);
    chk("ebk_flush_ignored", halted, 1'b1);
    chk("ebk_count", dec_count, 32'd1);
    do_reset();
    cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    chk("ebk_unhalt", halted, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] w;
      int r;
      r = $urandom_range(0, 99);
      if (r < 50)
        w = pool[$urandom_range(0, 7)];
      else if (r < 52)
        w = EBRK;
      else
        w = $urandom;
      if (m_halt && $urandom_range(0, 3) == 0)
        do_reset();
      else
        cycle($urandom_range(0, 3) != 0, w, {$urandom, $urandom},
              $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idu_ctrl.md
Name: idu_ctrl

Overview:
Decode-stage controller for the single-issue RV64 core. It sits between the IFU and EXU and holds one instruction in a decode register with valid/ready handshakes on both sides. It classifies the opcode and drives the 3-bit immediate-type select consumed by the sign-extension unit. It also extracts register indices, flags illegal encodings, and halts the front end after an ebreak.

Parameters:
PC_W, 64, width of the PC carried with each instruction
CNT_W, 32, width of the decoded-instruction counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  IFU presents an instruction
in_ready  output  1  controller can accept an instruction this cycle
in_instr  input  32  fetched instruction
in_pc  input  PC_W  PC of in_instr
flush  input  1  synchronous redirect; discard held and incoming instruction
out_valid  output  1  decode register holds an instruction for the EXU
out_ready  input  1  EXU consumes out_* this cycle
out_instr  output  32  held instruction
out_pc  output  PC_W  held PC
imm_sel  output  3  0=none/R, 1=I, 2=U, 3=S, 4=J, 5=B
rs1  output  5  instr[19:15]
rs2  output  5  instr[24:20]
rd  output  5  instr[11:7]
illegal  output  1  held instruction is unrecognised
is_ebreak  output  1  held instruction is ebreak (0x00100073)
halted  output  1  front end stopped after ebreak retired from decode
dec_count  output  CNT_W  number of instructions handed to the EXU

Behaviour:
- Reset (rst_n low, async): state=EMPTY. All outputs 0: out_valid, in_ready, imm_sel, decode fields, halted, and dec_count. in_ready goes to 1 on the first clock after reset release.
- States:
  - EMPTY: no instruction held.
  - FULL: instruction held, out_valid=1.
  - DRAIN: ebreak held, no new accepts.
  - HALT: terminal.
- in_ready:
  - EMPTY: 1 when flush=0.
  - FULL: equals out_ready when flush=0; pass-through, so a back-to-back accept and consume is allowed in the same cycle.
  - DRAIN and HALT: 0.
  - Any state: in_ready=0 whenever flush=1.
- accept = in_valid & in_ready.
- consume = out_valid & out_ready.
- Latency: an accepted instruction appears on out_* the next cycle. All decode outputs are registered at accept, and none are combinational from in_instr.
- Transitions (flush=0):
  - EMPTY: accept of non-ebreak -> FULL; accept of ebreak -> DRAIN.
  - FULL: consume & no accept -> EMPTY; consume & accept -> FULL or DRAIN (new instruction loaded); no consume -> hold, out_* stable.
  - DRAIN: consume -> HALT.
  - HALT: stays until reset; halted=1; out_valid=0.
- flush=1 (priority over everything except reset):
  - EMPTY, FULL, DRAIN -> EMPTY next cycle; out_valid drops next cycle.
  - Incoming beat is not accepted. A held instruction is not counted even if out_ready=1 that cycle.
  - HALT ignores flush.
- Decode (opcode = instr[6:0]):
  - 0000011, 0010011, 0011011, 1100111, 1110011 -> imm_sel=1.
  - 0110111, 0010111 -> 2.
  - 0100011 -> 3.
  - 1101111 -> 4.
  - 1100011 -> 5.
  - 0110011, 0111011 -> 0.
  - Any other opcode, including instr[1:0]!=2'b11 -> illegal=1, imm_sel=0.
  - illegal instructions pass through normally; they do not halt.
- is_ebreak=1 only for exact match 32'h00100073.
- dec_count increments by 1 on every consume that is not flushed. It wraps modulo 2^CNT_W with no saturation.
- out_* remain stable while out_valid=1 and out_ready=0 (AXI-style hold). When out_valid=0, out_* hold their last values, which are don't-care to consumers.

Test Plan:
- Reset then stream: in_valid=1 with addi x1,x0,5 (0x00500093) at pc 0x80000000, out_ready=1 -> next cycle out_valid=1, imm_sel=1, rd=1, rs1=0. Sustained 1 instruction/cycle; dec_count=N after N consumes.
- Classification sweep: lui 0x000012b7 -> 2; sw 0x00112023 -> 3; jal 0x008000ef -> 4; beq 0x00208463 -> 5; add 0x002081b3 -> 0. Word 0x0000007f -> illegal=1, imm_sel=0. Word 0x00000000 -> illegal=1.
- Backpressure: hold out_ready=0 for 5 cycles while FULL -> in_ready=0 and out_* unchanged. Release -> consume, next instruction accepted the same cycle.
- Flush: assert flush in FULL with out_ready=1 and in_valid=1 -> next cycle out_valid=0, state EMPTY, dec_count unchanged, incoming instruction not seen.
- Ebreak: accept 0x00100073 -> in_ready=0, is_ebreak=1. Consume -> halted=1 next cycle, in_ready stays 0. flush is ignored. Reset restores in_ready=1 and halted=0.
- Async reset mid-transfer: drop rst_n between clock edges while FULL -> out_valid, dec_count, and halted go to 0 immediately, without waiting for a clock edge.
